// File: rtl/i2c_defs.sv
// Shared definitions for the FALCON I2C configuration target.
// Holds the default bus address, the input glitch-filter length and the
// protocol state encoding used by i2c_slave_module.
package i2c_defs;

    // 0x48 appears as 0x90 (write) / 0x91 (read) on the wire, matching the camera side.
    localparam logic [6:0]  DEFAULT_DEVICE_ADDRESS = 7'h48;
    localparam int unsigned DEFAULT_FILTER_LENGTH  = 3;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        REG        = 4'd3,
        REG_ACK    = 4'd4,
        WR_HI      = 4'd5,
        WR_HI_ACK  = 4'd6,
        WR_LO      = 4'd7,
        WR_LO_ACK  = 4'd8,
        RD_HI      = 4'd9,
        RD_HI_MACK = 4'd10,
        RD_LO      = 4'd11,
        RD_LO_MACK = 4'd12,
        IGNORE     = 4'd13
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pad level: 2-FF synchronizer, glitch filter that
// needs FilterLength consecutive equal samples before the filtered level
// changes, and single-clk rise/fall pulses on the filtered level.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   raw          : raw pad level
//   level        : filtered level (idles high, like the bus)
//   rise, fall   : one-clk pulses coincident with a filtered level change
// Latency from raw to level/rise/fall is 2 + FilterLength clks.
module i2c_line_filter #(
    parameter int unsigned FilterLength = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (FilterLength > 1) ? $clog2(FilterLength) : 1;

    logic [1:0]      sync;
    logic [CntW-1:0] cnt;

    // Counter tracks how long the synchronized input has disagreed with the filtered level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CntW'(FilterLength - 1)) begin
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_slave_module.sv
// I2C target that lets an external host configure FALCON.
// Transaction: address byte, 8-bit register pointer, then 16-bit words MSB
// first (burst writes auto-increment the pointer). A read (R/W=1) streams
// 16-bit words fetched from the control fabric starting at the pointer.
// Ports:
//   clk, reset_n          : 50MHz clock, async active-low reset
//   scl_in, sda_in        : raw pad levels
//   sda_drive_low         : 1 = pull SDA low (open-drain)
//   wr_strobe             : one-clk pulse, wr_register/wr_data valid with it
//   rd_request            : one-clk pulse, rd_register valid with it
//   rd_data               : read word, sampled 2 clks after rd_request
//   busy                  : high from START until STOP (or reset)
module i2c_slave_module
    import i2c_defs::*;
#(
    parameter logic [6:0]  DeviceAddress = DEFAULT_DEVICE_ADDRESS,
    parameter int unsigned FilterLength  = DEFAULT_FILTER_LENGTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_drive_low,
    output logic        wr_strobe,
    output logic [7:0]  wr_register,
    output logic [15:0] wr_data,
    output logic        rd_request,
    output logic [7:0]  rd_register,
    input  logic [15:0] rd_data,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FilterLength(FilterLength)) u_scl_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FilterLength(FilterLength)) u_sda_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_state_e  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  ptr;
    logic [7:0]  hi_byte;
    logic [15:0] rd_word;
    logic        rd_pend;
    logic        rw;
    logic        ack_phase;   // set on the 9th SCL rise; the next fall ends the ACK slot
    logic [7:0]  rx_byte;

    assign rx_byte = {shift[6:0], sda_lvl};

    // Protocol engine: START/STOP override everything, otherwise bit/ACK sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            ptr           <= '0;
            hi_byte       <= '0;
            rd_word       <= '0;
            rd_pend       <= 1'b0;
            rw            <= 1'b0;
            ack_phase     <= 1'b0;
            sda_drive_low <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_register   <= '0;
            wr_data       <= '0;
            rd_request    <= 1'b0;
            rd_register   <= '0;
            busy          <= 1'b0;
        end else begin
            wr_strobe  <= 1'b0;
            rd_request <= 1'b0;
            // Fabric word is valid two clks after the request pulse.
            rd_pend    <= rd_request;
            if (rd_pend) begin
                rd_word <= rd_data;
            end

            if (scl_lvl && sda_fall) begin
                state         <= ADDR;
                bit_cnt       <= '0;
                shift         <= '0;
                ack_phase     <= 1'b0;
                sda_drive_low <= 1'b0;
                busy          <= 1'b1;
            end else if (scl_lvl && sda_rise) begin
                state         <= IDLE;
                bit_cnt       <= '0;
                ack_phase     <= 1'b0;
                sda_drive_low <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, WR_HI, WR_LO: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                case (state)
                                    ADDR: begin
                                        if (rx_byte[7:1] == DeviceAddress) begin
                                            rw    <= rx_byte[0];
                                            state <= ADDR_ACK;
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    REG: begin
                                        ptr   <= rx_byte;
                                        state <= REG_ACK;
                                    end
                                    WR_HI: begin
                                        hi_byte <= rx_byte;
                                        state   <= WR_HI_ACK;
                                    end
                                    default: begin
                                        wr_strobe   <= 1'b1;
                                        wr_register <= ptr;
                                        wr_data     <= {hi_byte, rx_byte};
                                        ptr         <= ptr + 8'd1;
                                        state       <= WR_LO_ACK;
                                    end
                                endcase
                            end
                        end
                    end

                    ADDR_ACK, REG_ACK, WR_HI_ACK, WR_LO_ACK: begin
                        if (scl_rise) begin
                            ack_phase <= 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                rd_request  <= 1'b1;
                                rd_register <= ptr;
                            end
                        end
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_drive_low <= 1'b1;
                            end else begin
                                bit_cnt       <= '0;
                                sda_drive_low <= 1'b0;
                                case (state)
                                    ADDR_ACK: begin
                                        if (rw) begin
                                            state         <= RD_HI;
                                            sda_drive_low <= ~rd_word[15];
                                        end else begin
                                            state <= REG;
                                        end
                                    end
                                    REG_ACK:   state <= WR_HI;
                                    WR_HI_ACK: state <= WR_LO;
                                    default:   state <= WR_HI;
                                endcase
                            end
                        end
                    end

                    RD_HI, RD_LO: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                state     <= (state == RD_HI) ? RD_HI_MACK : RD_LO_MACK;
                            end
                        end
                        // bit_cnt already points at the next bit to present.
                        if (scl_fall) begin
                            if (state == RD_HI) begin
                                sda_drive_low <= ~rd_word[{1'b1, ~bit_cnt}];
                            end else begin
                                sda_drive_low <= ~rd_word[{1'b0, ~bit_cnt}];
                            end
                        end
                    end

                    RD_HI_MACK, RD_LO_MACK: begin
                        if (scl_rise) begin
                            if (sda_lvl) begin
                                state         <= IGNORE;
                                sda_drive_low <= 1'b0;
                            end else begin
                                ack_phase <= 1'b1;
                                if (state == RD_LO_MACK) begin
                                    ptr         <= ptr + 8'd1;
                                    rd_request  <= 1'b1;
                                    rd_register <= ptr + 8'd1;
                                end
                            end
                        end
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_drive_low <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                if (state == RD_HI_MACK) begin
                                    state         <= RD_LO;
                                    sda_drive_low <= ~rd_word[7];
                                end else begin
                                    state         <= RD_HI;
                                    sda_drive_low <= ~rd_word[15];
                                end
                            end
                        end
                    end

                    default: begin
                        // IDLE and IGNORE wait for the next START/STOP.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_module.sv
// Directed bench for i2c_slave_module: a bit-banged I2C master drives the
// bus (wired-AND with the target's open-drain pull-down), monitors record
// write strobes and read requests, and a small fabric model answers reads.
module tb_i2c_slave_module;

    localparam int unsigned Q = 12;   // quarter SCL period in clks

    logic        clk = 1'b0;
    logic        reset_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_drive_low;
    logic        wr_strobe;
    logic [7:0]  wr_register;
    logic [15:0] wr_data;
    logic        rd_request;
    logic [7:0]  rd_register;
    logic [15:0] rd_data = 16'h0000;
    logic        busy;

    wire sda_bus = sda_m & ~sda_drive_low;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] wr_q[$];
    logic [7:0]  rdreg_q[$];
    int          drive_cycles = 0;

    always #10 clk = ~clk;

    i2c_slave_module dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .scl_in        (scl_m),
        .sda_in        (sda_bus),
        .sda_drive_low (sda_drive_low),
        .wr_strobe     (wr_strobe),
        .wr_register   (wr_register),
        .wr_data       (wr_data),
        .rd_request    (rd_request),
        .rd_register   (rd_register),
        .rd_data       (rd_data),
        .busy          (busy)
    );

    // Fabric model and bus monitors.
    always @(negedge clk) begin
        if (wr_strobe) wr_q.push_back({wr_register, wr_data});
        if (rd_request) begin
            rdreg_q.push_back(rd_register);
            case (rd_register)
                8'h04:   rd_data = 16'h09FF;
                8'h05:   rd_data = 16'h077F;
                default: rd_data = 16'hDEAD;
            endcase
        end
        if (sda_drive_low) drive_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Works for both a fresh START and a repeated START (SCL low on entry).
    task automatic bus_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        r = sda_bus;  wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            b = {b[6:0], r};
        end
        bit_xfer(~ack, r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         base;
        int         rbase;
        int         dbase;

        reset_n = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        wait_clks(4);
        check("reset sda_drive_low", sda_drive_low, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset wr_register", wr_register, 0);
        check("reset wr_data", wr_data, 0);
        check("reset rd_request", rd_request, 0);
        check("reset rd_register", rd_register, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(10);

        // Single word write.
        base = wr_q.size();
        bus_start();
        check("t1 busy after start", busy, 1);
        write_byte(8'h90, ack); check("t1 addr ack", ack, 1);
        write_byte(8'h23, ack); check("t1 reg ack", ack, 1);
        write_byte(8'h00, ack); check("t1 hi ack", ack, 1);
        write_byte(8'h33, ack); check("t1 lo ack", ack, 1);
        check("t1 busy before stop", busy, 1);
        bus_stop();
        check("t1 busy after stop", busy, 0);
        check("t1 strobe count", 32'(wr_q.size() - base), 1);
        check("t1 word", wr_q[base], 24'h230033);

        // Burst write with pointer wrap.
        base = wr_q.size();
        bus_start();
        write_byte(8'h90, ack); check("t2 addr ack", ack, 1);
        write_byte(8'hFF, ack); check("t2 reg ack", ack, 1);
        write_byte(8'h41, ack); check("t2 d0 ack", ack, 1);
        write_byte(8'h46, ack); check("t2 d1 ack", ack, 1);
        write_byte(8'h80, ack); check("t2 d2 ack", ack, 1);
        write_byte(8'h00, ack); check("t2 d3 ack", ack, 1);
        bus_stop();
        check("t2 strobe count", 32'(wr_q.size() - base), 2);
        check("t2 word0", wr_q[base], 24'hFF4146);
        check("t2 word1 wrapped", wr_q[base + 1], 24'h008000);

        // Foreign address is ignored; a following START to us is served.
        base  = wr_q.size();
        dbase = drive_cycles;
        bus_start();
        write_byte(8'h92, ack); check("t3 foreign addr nack", ack, 0);
        write_byte(8'h23, ack); check("t3 b0 nack", ack, 0);
        write_byte(8'h00, ack); check("t3 b1 nack", ack, 0);
        write_byte(8'h33, ack); check("t3 b2 nack", ack, 0);
        check("t3 sda never driven", 32'(drive_cycles - dbase), 0);
        check("t3 busy while ignoring", busy, 1);
        bus_start();
        write_byte(8'h90, ack); check("t3 addr ack after restart", ack, 1);
        write_byte(8'h10, ack); check("t3 reg ack after restart", ack, 1);
        bus_stop();
        check("t3 strobe count", 32'(wr_q.size() - base), 0);

        // Pointer set, repeated START, two-word read.
        base  = wr_q.size();
        rbase = rdreg_q.size();
        bus_start();
        write_byte(8'h90, ack); check("t4 addr ack", ack, 1);
        write_byte(8'h04, ack); check("t4 reg ack", ack, 1);
        bus_start();
        write_byte(8'h91, ack); check("t4 read addr ack", ack, 1);
        read_byte(rb, 1'b1); check("t4 rd byte0", rb, 8'h09);
        read_byte(rb, 1'b1); check("t4 rd byte1", rb, 8'hFF);
        read_byte(rb, 1'b1); check("t4 rd byte2", rb, 8'h07);
        read_byte(rb, 1'b0); check("t4 rd byte3", rb, 8'h7F);
        check("t4 released after nack", sda_drive_low, 0);
        bus_stop();
        check("t4 rd_request count", 32'(rdreg_q.size() - rbase), 2);
        check("t4 rd_register 0", rdreg_q[rbase], 8'h04);
        check("t4 rd_register 1", rdreg_q[rbase + 1], 8'h05);
        check("t4 no strobes", 32'(wr_q.size() - base), 0);

        // SCL glitch before the hi byte, then STOP with only the hi byte sent.
        base = wr_q.size();
        bus_start();
        write_byte(8'h90, ack); check("t5 addr ack", ack, 1);
        write_byte(8'h30, ack); check("t5 reg ack", ack, 1);
        sda_m = 1'b1;
        scl_m = 1'b1; wait_clks(1);
        scl_m = 1'b0; wait_clks(Q);
        write_byte(8'hA5, ack); check("t5 hi ack aligned", ack, 1);
        bus_stop();
        check("t5 no strobe", 32'(wr_q.size() - base), 0);
        check("t5 busy after stop", busy, 0);

        // Asynchronous reset in the middle of the lo data byte.
        base = wr_q.size();
        bus_start();
        write_byte(8'h90, ack); check("t6 addr ack", ack, 1);
        write_byte(8'h11, ack); check("t6 reg ack", ack, 1);
        write_byte(8'h22, ack); check("t6 hi ack", ack, 1);
        for (int i = 0; i < 3; i++) bit_xfer(1'b0, ack);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        check("t6 busy before reset", busy, 1);
        #2 reset_n = 1'b0;
        #2;
        check("t6 sda released by reset", sda_drive_low, 0);
        check("t6 busy cleared by reset", busy, 0);
        wait_clks(5);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(10);
        check("t6 no strobe from aborted word", 32'(wr_q.size() - base), 0);
        bus_start();
        write_byte(8'h90, ack); check("t6 post addr ack", ack, 1);
        write_byte(8'h42, ack); check("t6 post reg ack", ack, 1);
        write_byte(8'hBE, ack); check("t6 post hi ack", ack, 1);
        write_byte(8'hEF, ack); check("t6 post lo ack", ack, 1);
        bus_stop();
        check("t6 post strobe count", 32'(wr_q.size() - base), 1);
        check("t6 post word", wr_q[base], 24'h42BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
